// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the uart_phy bit-level UART.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Width of a down-counter that must hold DIVISOR-1.
    function automatic int baud_cnt_w(input int divisor);
        return (divisor <= 2) ? 1 : $clog2(divisor);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver: 2-flop rx synchroniser, centre-sampling FSM.
//                Even parity checked when UART_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int DIVISOR = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_error
);
    import uart_pkg::*;

    localparam int              CW          = baud_cnt_w(DIVISOR);
    localparam logic [CW-1:0]   C_FULL      = CW'(DIVISOR - 1);
    localparam logic [CW-1:0]   C_HALF      = CW'(DIVISOR / 2 - 1);
    localparam logic [2:0]      C_LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic              r_rx_meta;
    logic              r_rx_s;
    logic              r_rx_s_d;
    uart_state_t       r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              w_fall;
`ifdef UART_PARITY_EN
    logic              r_par_err;
`endif

    assign w_fall = r_rx_s_d & ~r_rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            rx_data   <= '0;
            rx_ready  <= 1'b0;
            rx_error  <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
            rx_ready  <= 1'b0;
            rx_error  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= C_HALF;
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (r_rx_s) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt     <= C_FULL;
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_cnt   <= C_FULL;
                        if (r_bit_cnt == C_LAST_BIT) begin
`ifdef UART_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_par_err <= r_rx_s ^ (^r_shift);
                        r_cnt     <= C_FULL;
                        r_state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_state <= IDLE;
`ifdef UART_PARITY_EN
                        if (r_rx_s && !r_par_err) begin
`else
                        if (r_rx_s) begin
`endif
                            rx_data  <= r_shift;
                            rx_ready <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_phy.sv
// ============================================================================
//  Module      : uart_phy
//  Description : 8N1 UART PHY, fixed integer baud divisor. TX FSM inline,
//                receiver in uart_rx. Define UART_PARITY_EN for 8E1 framing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_phy #(
    parameter int DIVISOR = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_error
);
    import uart_pkg::*;

    localparam int              CW          = baud_cnt_w(DIVISOR);
    localparam logic [CW-1:0]   C_FULL      = CW'(DIVISOR - 1);
    localparam logic [2:0]      C_LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_t       r_tx_state;
    logic [CW-1:0]     r_tx_cnt;
    logic [2:0]        r_tx_bit;
    logic [7:0]        r_tx_shift;
`ifdef UART_PARITY_EN
    logic              r_tx_par;
`endif

    // The tx_ready cycle itself is not accepted, so a follow-on request lands
    // in the first idle cycle after the pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            tx         <= 1'b1;
            tx_ready   <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            tx_ready <= 1'b0;
            case (r_tx_state)
                IDLE: begin
                    if (tx_req && !tx_ready) begin
                        r_tx_shift <= tx_data;
`ifdef UART_PARITY_EN
                        r_tx_par   <= ^tx_data;
`endif
                        tx         <= 1'b0;
                        r_tx_cnt   <= C_FULL;
                        r_tx_state <= START;
                    end
                end
                START: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - CW'(1);
                    end else begin
                        tx         <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= '0;
                        r_tx_cnt   <= C_FULL;
                        r_tx_state <= DATA;
                    end
                end
                DATA: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - CW'(1);
                    end else begin
                        r_tx_cnt <= C_FULL;
                        if (r_tx_bit == C_LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx         <= r_tx_par;
                            r_tx_state <= PARITY;
`else
                            tx         <= 1'b1;
                            r_tx_state <= STOP;
`endif
                        end else begin
                            tx         <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - CW'(1);
                    end else begin
                        tx         <= 1'b1;
                        r_tx_cnt   <= C_FULL;
                        r_tx_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - CW'(1);
                    end else begin
                        tx_ready   <= 1'b1;
                        r_tx_state <= IDLE;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

    uart_rx #(
        .DIVISOR (DIVISOR)
    ) u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_error (rx_error)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart_phy.sv
// ============================================================================
//  Module      : tb_uart_phy
//  Description : Self-checking bench for uart_phy at DIVISOR=8; follows
//                UART_PARITY_EN for the frame length and parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_phy;

    localparam int DIV = 8;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int C_RX_LAT = 2 + DIV / 2 + (NB - 1) * DIV;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx = 1'b1;
    logic       tx_ready, tx, rx_ready, rx_error;
    logic [7:0] rx_data;

    uart_phy #(.DIVISOR(DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (tx),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_error (rx_error)
    );

    always #5 clk = ~clk;

    int         tests = 0, fails = 0;
    int         cyc = 0;
    int         n_txr = 0, n_rxr = 0, n_rxe = 0;
    int         txr_cyc = 0, rxr_cyc = 0;
    logic [7:0] rx_cap = 8'h00;
    logic [7:0] model_rx = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (tx_ready) begin n_txr++; txr_cyc = cyc; end
            if (rx_ready) begin n_rxr++; rxr_cyc = cyc; rx_cap = rx_data; end
            if (rx_error) n_rxe++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Line image of one frame, index 0 = start bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic stop, input logic flip);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_PARITY_EN
        f[9]   = (^b) ^ flip;
`else
        if (flip) f[9] = 1'b1;
`endif
        f[NB-1] = stop;
        return f;
    endfunction

    // Returns at the negedge of the tx_ready cycle.
    task automatic tx_frame(input logic [7:0] b, input bit mid_req);
        logic [10:0] f;
        int t0, n0;
        f  = frame_bits(b, 1'b1, 1'b0);
        n0 = n_txr;
        @(negedge clk);
        tx_data = b;
        tx_req  = 1'b1;
        @(posedge clk); #1;
        t0      = cyc;
        tx_req  = 1'b0;
        tx_data = 8'h00;
        check("tx start falls", tx, 1'b0);
        repeat (DIV / 2 - 1) @(posedge clk);
        for (int k = 0; k < NB; k++) begin
            #1;
            check($sformatf("tx bit %0d of %02h", k, b), tx, f[k]);
            if (k == NB - 1) break;
            if (mid_req && k == 4) begin
                tx_data = 8'h3C;
                tx_req  = 1'b1;
                @(posedge clk); #1;
                tx_req  = 1'b0;
                repeat (DIV - 1) @(posedge clk);
            end else begin
                repeat (DIV) @(posedge clk);
            end
        end
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (n_txr != n0) break;
        end
        check("tx_ready count", n_txr - n0, 1);
        check("tx_ready latency", txr_cyc - t0, DIV * NB);
        check("tx idle high", tx, 1'b1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input logic flip,
                            input logic exp_good, input logic [7:0] exp_data);
        logic [10:0] f;
        int t0, nr0, ne0;
        f   = frame_bits(b, stop, flip);
        nr0 = n_rxr;
        ne0 = n_rxe;
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 0; k < NB; k++) begin
            rx = f[k];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (DIV) @(negedge clk);
        check($sformatf("rx_ready count %02h", b), n_rxr - nr0, exp_good ? 1 : 0);
        check($sformatf("rx_error count %02h", b), n_rxe - ne0, exp_good ? 0 : 1);
        if (exp_good) begin
            check_range("rx_ready latency", rxr_cyc - t0, C_RX_LAT - 1, C_RX_LAT + 1);
            check("rx_data at pulse", rx_cap, exp_data);
        end
        check("rx_data held", rx_data, exp_data);
    endtask

    typedef struct {
        bit         is_rx;
        logic [7:0] data;
        logic       stop;
        logic       exp_good;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int nr0, ne0, nt0;
        logic [7:0] b;
        logic stop;
        logic [7:0] exp;

        vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b1, 8'h00};
        vecs[1] = '{1'b0, 8'h07, 1'b1, 1'b1, 8'h00};
        vecs[2] = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A};
        vecs[3] = '{1'b1, 8'h81, 1'b0, 1'b0, 8'h5A};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00};

        repeat (3) @(negedge clk);
        check("reset tx", tx, 1'b1);
        check("reset tx_ready", tx_ready, 1'b0);
        check("reset rx_ready", rx_ready, 1'b0);
        check("reset rx_error", rx_error, 1'b0);
        check("reset rx_data", rx_data, 8'h00);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_rx) begin
                rx_frame(vecs[i].data, vecs[i].stop, 1'b0, vecs[i].exp_good, vecs[i].exp_data);
                model_rx = vecs[i].exp_data;
            end else begin
                tx_frame(vecs[i].data, 1'b0);
            end
            repeat (2) @(negedge clk);
        end

        // Mid-frame request dropped, then back-to-back frame with no gap.
        tx_frame(8'hA5, 1'b1);
        tx_frame(8'h3C, 1'b0);
        nt0 = n_txr;
        repeat (4 * DIV) @(negedge clk);
        check("no queued tx frame", n_txr - nt0, 0);
        check("tx stays idle", tx, 1'b1);

        // Two-cycle low glitch is a false start.
        nr0 = n_rxr; ne0 = n_rxe;
        @(posedge clk); #1; rx = 1'b0;
        repeat (2) @(posedge clk); #1; rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch rx_ready", n_rxr - nr0, 0);
        check("glitch rx_error", n_rxe - ne0, 0);
        rx_frame(8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF);
        model_rx = 8'hFF;

`ifdef UART_PARITY_EN
        rx_frame(8'h33, 1'b1, 1'b1, 1'b0, model_rx);
`endif

        // Reset pulse while both directions are mid-frame.
        @(negedge clk);
        tx_data = 8'hC3; tx_req = 1'b1; rx = 1'b0;
        @(negedge clk);
        tx_req = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        nr0 = n_rxr; ne0 = n_rxe; nt0 = n_txr;
        #2 reset_n = 1'b0;
        #1;
        check("async reset tx", tx, 1'b1);
        check("async reset tx_ready", tx_ready, 1'b0);
        check("async reset rx_ready", rx_ready, 1'b0);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        reset_n = 1'b1;
        model_rx = 8'h00;
        repeat (12 * DIV) @(negedge clk);
        check("no tx_ready after abort", n_txr - nt0, 0);
        check("no rx_ready after abort", n_rxr - nr0, 0);
        check("no rx_error after abort", n_rxe - ne0, 0);
        check("rx_data reset", rx_data, 8'h00);
        tx_frame(8'h96, 1'b0);
        rx_frame(8'h69, 1'b1, 1'b0, 1'b1, 8'h69);
        model_rx = 8'h69;

        // Randomised traffic against the reference model.
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                tx_frame(b, 1'b0);
            end else begin
                stop = ($urandom_range(0, 3) != 0);
                exp  = stop ? b : model_rx;
                rx_frame(b, stop, 1'b0, stop, exp);
                model_rx = exp;
            end
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
